// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix keypad scanner.
// Key codes are row_idx*4 + col_idx; the board legend is printed in that same order.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    localparam logic [3:0] COL_RESET = 4'b1110;

    localparam logic [3:0] KEY_0 = 4'h0;
    localparam logic [3:0] KEY_1 = 4'h1;
    localparam logic [3:0] KEY_2 = 4'h2;
    localparam logic [3:0] KEY_3 = 4'h3;
    localparam logic [3:0] KEY_4 = 4'h4;
    localparam logic [3:0] KEY_5 = 4'h5;
    localparam logic [3:0] KEY_6 = 4'h6;
    localparam logic [3:0] KEY_7 = 4'h7;
    localparam logic [3:0] KEY_8 = 4'h8;
    localparam logic [3:0] KEY_9 = 4'h9;
    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] KEY_C = 4'hC;
    localparam logic [3:0] KEY_D = 4'hD;
    localparam logic [3:0] KEY_E = 4'hE;
    localparam logic [3:0] KEY_F = 4'hF;

    localparam logic [3:0] KEY_MAP [16] = '{
        KEY_0, KEY_1, KEY_2, KEY_3, KEY_4, KEY_5, KEY_6, KEY_7,
        KEY_8, KEY_9, KEY_A, KEY_B, KEY_C, KEY_D, KEY_E, KEY_F
    };

    // Lowest-index active-low row wins when several rows are pulled down.
    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        casez (rows)
            4'b???0: lowest_low = 2'd0;
            4'b??01: lowest_low = 2'd1;
            4'b?011: lowest_low = 2'd2;
            default: lowest_low = 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] col_index(input logic [3:0] cols);
        case (cols)
            4'b1101: col_index = 2'd1;
            4'b1011: col_index = 2'd2;
            4'b0111: col_index = 2'd3;
            default: col_index = 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        key_code = KEY_MAP[{r, c}];
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad pin and key-event bundle; master is the scanner, slave is the board/consumer side.
interface keypad_scan_if;

    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row,
        output col,
        output key,
        output key_valid,
        output key_held
    );

    modport slave (
        output row,
        input  col,
        input  key,
        input  key_valid,
        input  key_held
    );

endinterface

// File: rtl/scan_tick.sv
// Free-running prescaler: one-clock tick every CLK_DIV clocks (count wraps at CLK_DIV-1).
module scan_tick #(
    parameter int unsigned CLK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    always_comb tick = (count == LAST);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, row sync, press/release debounce, key strobe.
// Optional auto-repeat while held is compiled in with `define KEYPAD_REPEAT_EN.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 50000,
    parameter int unsigned DEBOUNCE_TICKS = 20,
    parameter int unsigned REPEAT_DELAY   = 500,
    parameter int unsigned REPEAT_RATE    = 100
) (
    input  logic           clk,
    input  logic           rst,
    keypad_scan_if.master  bus
);

    // An illegal configuration falls back to the fastest divider so it is obvious on the pins.
    localparam bit CFG_OK = (CLK_DIV >= 2) && (DEBOUNCE_TICKS >= 1) &&
                            (REPEAT_DELAY >= 1) && (REPEAT_RATE >= 1);
    localparam int unsigned DIV = CFG_OK ? CLK_DIV : 2;

    localparam int unsigned CNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic             tick;
    logic [3:0]       row_m, row_s;
    state_t           state, state_n;
    logic [3:0]       col, col_n;
    logic [1:0]       col_idx, col_idx_n;
    logic [1:0]       row_idx, row_idx_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       key, key_n;
    logic             key_valid, valid_n;
    logic             key_held, held_n;
    logic             latched_low;
    logic             any_low;

    scan_tick #(.CLK_DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_m <= '1;
            row_s <= '1;
        end else begin
            row_m <= bus.row;
            row_s <= row_m;
        end
    end

    always_comb begin
        latched_low = ~row_s[row_idx];
        any_low     = (row_s != 4'hF);
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt, rpt_n;

    // Down-counter to the next repeat: loaded with the delay on acceptance (or on a
    // release bounce back into HELD), then with the rate after every repeat pulse.
    always_comb begin
        rpt_n = rpt;
        if (tick) begin
            if (state == DEBOUNCE && latched_low && cnt == DB_LAST) begin
                rpt_n = RPT_W'(REPEAT_DELAY);
            end else if (state == HELD) begin
                if (!latched_low) begin
                    rpt_n = '0;
                end else if (rpt == RPT_W'(1)) begin
                    rpt_n = RPT_W'(REPEAT_RATE);
                end else if (rpt != '0) begin
                    rpt_n = rpt - 1'b1;
                end
            end else if (state == RELEASE && latched_low) begin
                rpt_n = RPT_W'(REPEAT_DELAY);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt <= '0;
        end else begin
            rpt <= rpt_n;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SCAN;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (tick) begin
            case (state)
                SCAN:     if (any_low) state_n = DEBOUNCE;
                DEBOUNCE: begin
                    if (!latched_low)        state_n = SCAN;
                    else if (cnt == DB_LAST) state_n = HELD;
                end
                HELD:     if (!latched_low) state_n = RELEASE;
                RELEASE: begin
                    if (latched_low)         state_n = HELD;
                    else if (cnt == DB_LAST) state_n = SCAN;
                end
            endcase
        end
    end

    always_comb begin
        col_n     = col;
        col_idx_n = col_idx;
        row_idx_n = row_idx;
        cnt_n     = cnt;
        key_n     = key;
        valid_n   = 1'b0;
        held_n    = key_held;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (!any_low) begin
                        col_n = {col[2:0], col[3]};
                    end else begin
                        row_idx_n = lowest_low(row_s);
                        col_idx_n = col_index(col);
                        cnt_n     = '0;
                    end
                end
                DEBOUNCE: begin
                    if (latched_low) begin
                        if (cnt == DB_LAST) begin
                            key_n   = key_code(row_idx, col_idx);
                            valid_n = 1'b1;
                            held_n  = 1'b1;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (!latched_low) begin
                        cnt_n = '0;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else begin
                        valid_n = (rpt == RPT_W'(1));
                    end
`endif
                end
                RELEASE: begin
                    if (!latched_low) begin
                        if (cnt == DB_LAST) begin
                            held_n = 1'b0;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= COL_RESET;
            col_idx   <= '0;
            row_idx   <= '0;
            cnt       <= '0;
            key       <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            col       <= col_n;
            col_idx   <= col_idx_n;
            row_idx   <= row_idx_n;
            cnt       <= cnt_n;
            key       <= key_n;
            key_valid <= valid_n;
            key_held  <= held_n;
        end
    end

    always_comb begin
        bus.col       = col;
        bus.key       = key;
        bus.key_valid = key_valid;
        bus.key_held  = key_held;
    end

endmodule
